edge_scan_ctrl: RTL and testbench



---
 rtl/edge_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_edge_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_scan_ctrl.sv
// Raster-scan controller for edgedetect: buffers two lines plus a 3x3 window of a grayscale
// stream and returns one edge flag per pixel, in raster order, through a valid/ready output.
module edge_scan_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [PIX_W-1:0]   threshold,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] grid_out,
    output logic [PIX_W-1:0]   thresh_out,
    input  logic               is_edge_in,
    output logic               edge_valid,
    output logic               edge_out,
    input  logic               edge_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int N_STEP = N_PIX + IMG_W + 1;
    localparam int STEP_W = $clog2(N_STEP + 1);
    localparam int OUT_W  = $clog2(N_PIX + 1);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    localparam logic [STEP_W-1:0] STEP_FIRST_OUT = STEP_W'(IMG_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST_PIX  = STEP_W'(N_PIX - 1);
    localparam logic [STEP_W-1:0] STEP_END       = STEP_W'(N_STEP);
    localparam logic [OUT_W-1:0]  OUT_LAST       = OUT_W'(N_PIX - 1);
    localparam logic [COL_W-1:0]  COL_LAST       = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST       = ROW_W'(IMG_H - 1);

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_frame_done;
    logic [PIX_W-1:0]   r_thresh;
    logic [9*PIX_W-1:0] r_win;
    logic [PIX_W-1:0]   r_lb0 [IMG_W];
    logic [PIX_W-1:0]   r_lb1 [IMG_W];
    logic [COL_W-1:0]   r_col;
    logic [STEP_W-1:0]  r_step;
    logic [COL_W-1:0]   r_pcol;
    logic [ROW_W-1:0]   r_prow;
    logic               r_pend;
    logic               r_pbord;
    logic               r_edge_valid;
    logic               r_edge_out;
    logic [OUT_W-1:0]   r_out_cnt;

    logic               w_start;
    logic               w_capture;
    logic               w_slot;
    logic               w_step;
    logic               w_produce;
    logic               w_hs;
    logic               w_last_hs;
    logic               w_border;
    logic [PIX_W-1:0]   w_top;
    logic [PIX_W-1:0]   w_mid;
    logic [PIX_W-1:0]   w_bot;
    logic [9*PIX_W-1:0] w_win_nxt;

    assign w_start   = (r_state == S_IDLE) & start;
    assign w_capture = r_pend & (~r_edge_valid | edge_ready);
    assign w_slot    = ~r_pend | w_capture;
    assign pix_ready = (r_state == S_RUN) & w_slot;
    // Drain steps push zero columns so the last rows reach the window center.
    assign w_step    = (pix_valid & pix_ready) |
                       ((r_state == S_DRAIN) & (r_step != STEP_END) & w_slot);
    assign w_produce = w_step & (r_step >= STEP_FIRST_OUT);
    assign w_hs      = r_edge_valid & edge_ready;
    assign w_last_hs = w_hs & (r_out_cnt == OUT_LAST);
    assign w_border  = (r_prow == '0) | (r_prow == ROW_LAST) |
                       (r_pcol == '0) | (r_pcol == COL_LAST);

    assign w_top     = r_lb1[r_col];
    assign w_mid     = r_lb0[r_col];
    assign w_bot     = (r_state == S_RUN) ? pix_data : '0;
    // Shift window left; new column enters on the right (p02/p12/p22).
    assign w_win_nxt = {r_win[8*PIX_W-1 -: 2*PIX_W], w_top,
                        r_win[5*PIX_W-1 -: 2*PIX_W], w_mid,
                        r_win[2*PIX_W-1 -: 2*PIX_W], w_bot};

    assign grid_out   = r_win;
    assign thresh_out = r_thresh;
    assign edge_valid = r_edge_valid;
    assign edge_out   = r_edge_out;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_thresh     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_thresh <= threshold;
                    end
                end
                S_RUN: begin
                    if (w_step && r_step == STEP_LAST_PIX) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_hs) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_win  <= '0;
            r_col  <= '0;
            r_step <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else if (w_start) begin
            r_col  <= '0;
            r_step <= '0;
        end else if (w_step) begin
            r_win        <= w_win_nxt;
            r_lb1[r_col] <= w_mid;
            r_lb0[r_col] <= w_bot;
            r_col        <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
            r_step       <= r_step + STEP_W'(1);
        end
    end

    // r_pcol/r_prow track the center position of the next output to be produced.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pend  <= 1'b0;
            r_pbord <= 1'b0;
            r_pcol  <= '0;
            r_prow  <= '0;
        end else if (w_start) begin
            r_pend <= 1'b0;
            r_pcol <= '0;
            r_prow <= '0;
        end else if (w_produce) begin
            r_pend  <= 1'b1;
            r_pbord <= w_border;
            if (r_pcol == COL_LAST) begin
                r_pcol <= '0;
                r_prow <= r_prow + ROW_W'(1);
            end else begin
                r_pcol <= r_pcol + COL_W'(1);
            end
        end else if (w_capture) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_edge_valid <= 1'b0;
            r_edge_out   <= 1'b0;
            r_out_cnt    <= '0;
        end else if (w_start) begin
            r_edge_valid <= 1'b0;
            r_edge_out   <= 1'b0;
            r_out_cnt    <= '0;
        end else begin
            if (w_capture) begin
                r_edge_valid <= 1'b1;
                r_edge_out   <= r_pbord ? 1'b0 : is_edge_in;
            end else if (w_hs) begin
                r_edge_valid <= 1'b0;
            end
            if (w_hs) begin
                r_out_cnt <= r_out_cnt + OUT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Scoreboard bench for edge_scan_ctrl on a 4x3 frame: expected flags are queued at stimulus
// time and a negedge monitor pops them on every output handshake.
module tb_edge_scan_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int P = 8;
    localparam int N = W * H;
    localparam logic [9*P-1:0] GRID5 = 72'h00_01_02_04_05_06_08_09_0A;

    logic           clk = 1'b0;
    logic           n_rst = 1'b1;
    logic           start = 1'b0;
    logic [P-1:0]   threshold = '0;
    logic           pix_valid = 1'b0;
    logic [P-1:0]   pix_data = '0;
    logic           pix_ready;
    logic [9*P-1:0] grid_out;
    logic [P-1:0]   thresh_out;
    logic           is_edge_in;
    logic           edge_valid;
    logic           edge_out;
    logic           edge_ready = 1'b1;
    logic           busy;
    logic           frame_done;

    int edge_mode = 0;
    int errors = 0;
    int checks = 0;
    int n_out = 0;
    int n_done = 0;
    bit exp_q[$];
    bit hold_v = 1'b0;
    bit hold_val = 1'b0;

    // Stand-in for edgedetect: mode 0 always flags, mode 1 flags only the known grid of output 5.
    assign is_edge_in = (edge_mode == 0) ? 1'b1 : (grid_out == GRID5);

    edge_scan_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .threshold  (threshold),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .grid_out   (grid_out),
        .thresh_out (thresh_out),
        .is_edge_in (is_edge_in),
        .edge_valid (edge_valid),
        .edge_out   (edge_out),
        .edge_ready (edge_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (hold_v) begin
                check("edge_valid held under backpressure", edge_valid, 1'b1);
                check("edge_out held under backpressure", edge_out, hold_val);
            end
            if (edge_valid && edge_ready) begin
                if (exp_q.size() == 0) begin
                    fail($sformatf("unexpected output %0d value %0b", n_out, edge_out));
                end else begin
                    check($sformatf("edge_out[%0d]", n_out), edge_out, exp_q.pop_front());
                end
                n_out++;
            end
            if (frame_done) n_done++;
            hold_v   = edge_valid && !edge_ready;
            hold_val = edge_out;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic do_start(input logic [P-1:0] th);
        start     = 1'b1;
        threshold = th;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // kind 0: flat 0x10 pixels; kind 1: pixel = raster index. glitch_at injects a stray start.
    task automatic send_pixels(input int kind, input int count, input int glitch_at);
        for (int i = 0; i < count; i++) begin
            int w;
            pix_valid = 1'b0;
            if (i == glitch_at) begin
                threshold = 8'h77;
                start     = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            pix_data  = (kind == 1) ? P'(i) : 8'h10;
            pix_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!pix_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) fail($sformatf("timeout waiting pix_ready for pixel %0d", i));
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int out0, input int done0);
        int w;
        w = 0;
        while (n_done == done0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) fail({tag, " timeout waiting frame_done"});
        repeat (3) @(posedge clk);
        #1;
        check({tag, " output count"}, n_out - out0, N);
        check({tag, " frame_done pulses"}, n_done - done0, 1);
        check({tag, " busy low after frame"}, busy, 1'b0);
        check({tag, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    task automatic push_expected(input int kind);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back((i == 5) || (i == 6 && kind == 0));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " pix_ready"}, pix_ready, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " edge_valid"}, edge_valid, 1'b0);
        check({tag, " edge_out"}, edge_out, 1'b0);
        check({tag, " frame_done"}, frame_done, 1'b0);
        check({tag, " grid_out"}, grid_out, 72'h0);
        check({tag, " thresh_out"}, thresh_out, 8'h0);
    endtask

    initial begin
        int out0;
        int done0;
        #1 n_rst = 1'b0;
        #2;
        check_cleared("reset");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'h55;
        repeat (2) @(negedge clk);
        check("idle pix_ready with pix_valid", pix_ready, 1'b0);
        check("idle busy", busy, 1'b0);
        @(posedge clk);
        #1 pix_valid = 1'b0;

        // Frame A: flat image, edge tied high, stray start mid-frame.
        edge_mode = 0;
        out0  = n_out;
        done0 = n_done;
        push_expected(0);
        do_start(8'h40);
        check("busy after start", busy, 1'b1);
        send_pixels(0, N, 4);
        check("thresh_out held through stray start", thresh_out, 8'h40);
        finish_frame("frame A", out0, done0);

        // Frame B: raster-index pixels, grid ordering probe, 5-cycle backpressure.
        edge_mode = 1;
        out0  = n_out;
        done0 = n_done;
        push_expected(1);
        do_start(8'h20);
        fork
            send_pixels(1, N, -1);
            begin
                repeat (8) @(posedge clk);
                #1 edge_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("pix_ready low while stalled", pix_ready, 1'b0);
                @(posedge clk);
                #1 edge_ready = 1'b1;
            end
        join
        finish_frame("frame B", out0, done0);

        // Abandoned frame: reset asynchronously after 6 pixels.
        edge_mode = 0;
        do_start(8'h33);
        send_pixels(0, 6, -1);
        #2 n_rst = 1'b0;
        #1;
        check_cleared("mid-frame reset");
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Frame C: fresh frame after the abort.
        out0  = n_out;
        done0 = n_done;
        push_expected(0);
        do_start(8'h40);
        send_pixels(0, N, -1);
        finish_frame("frame C", out0, done0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
